// File: rtl/led_status_pkg.sv
// Shared types and constants for the LED status driver.
package led_status_pkg;

   localparam int unsigned LED_W   = 8;
   localparam int unsigned PARAM_W = 6;

   // Display mode, taken from the top two bits of the PIO word.
   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_PWM    = 2'b10,
      MODE_CHASE  = 2'b11
   } led_mode_t;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, restartable via clr.
module led_tick_gen #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TW-1:0] cnt_q;

   assign tick = (cnt_q == TW'(TICK_DIV - 1));

   // Count 0..TICK_DIV-1 and wrap; clr restarts the period from 0.
   always_ff @(posedge clk_clk) begin
      if (reset_reset || clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/led_status_driver.sv
// Turns the firmware PIO word into a registered LED drive with
// static, blink, PWM-dim and chase display modes.
module led_status_driver
   import led_status_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 50000,
   parameter int unsigned BLINK_TICKS = 250,
   parameter int unsigned CHASE_TICKS = 100,
   parameter int unsigned PWM_BITS    = 4
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [LED_W-1:0] pio_word,
   output logic [LED_W-1:0] led
);

   localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int unsigned CW = (CHASE_TICKS > 1) ? $clog2(CHASE_TICKS) : 1;

   logic [LED_W-1:0]    word_q, word_d;
   logic                change;
   logic                tick;
   logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                phase_q, phase_d;
   logic [CW-1:0]       chase_cnt_q, chase_cnt_d;
   logic [LED_W-1:0]    pos_q, pos_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [LED_W-1:0]    led_q, led_d;
   led_mode_t           mode;

   // Any difference from the last sampled word restarts all timing.
   assign change = (pio_word != word_q);

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .clr         (change),
      .tick        (tick)
   );

   // Next state for blink phase, chase position and PWM; a word change overrides any tick.
   always_comb begin
      word_d      = word_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      chase_cnt_d = chase_cnt_q;
      pos_d       = pos_q;
      pwm_cnt_d   = pwm_cnt_q + 1'b1;
      // Duty only moves at a period boundary so no partial PWM periods appear.
      duty_d      = (pwm_cnt_d == '0) ? word_q[PWM_BITS-1:0] : duty_q;

      if (tick) begin
         if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end

         if (chase_cnt_q == CW'(CHASE_TICKS - 1)) begin
            chase_cnt_d = '0;
            pos_d       = word_q[0] ? {pos_q[0], pos_q[LED_W-1:1]}
                                    : {pos_q[LED_W-2:0], pos_q[LED_W-1]};
         end else begin
            chase_cnt_d = chase_cnt_q + 1'b1;
         end
      end

      if (change) begin
         word_d      = pio_word;
         blink_cnt_d = '0;
         phase_d     = 1'b1;
         chase_cnt_d = '0;
         pos_d       = pio_word[0] ? LED_W'(8'h80) : LED_W'(8'h01);
         pwm_cnt_d   = '0;
         duty_d      = pio_word[PWM_BITS-1:0];
      end
   end

   // Mode mux on next-state values so a new word shows up one clock after it is written.
   always_comb begin
      led_d = '0;
      mode  = led_mode_t'(word_d[LED_W-1:PARAM_W]);
      unique case (mode)
         MODE_STATIC: led_d = {{(LED_W - PARAM_W){1'b0}}, word_d[PARAM_W-1:0]};
         MODE_BLINK:  led_d = phase_d ? {{(LED_W - PARAM_W){1'b0}}, word_d[PARAM_W-1:0]} : '0;
         MODE_PWM:    led_d = (pwm_cnt_d < duty_d) ? '1 : '0;
         MODE_CHASE:  led_d = pos_d;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         word_q      <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         chase_cnt_q <= '0;
         pos_q       <= LED_W'(8'h01);
         pwm_cnt_q   <= '0;
         duty_q      <= '0;
         led_q       <= '0;
      end else begin
         word_q      <= word_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         chase_cnt_q <= chase_cnt_d;
         pos_q       <= pos_d;
         pwm_cnt_q   <= pwm_cnt_d;
         duty_q      <= duty_d;
         led_q       <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: doc/led_status_driver.md
# led_status_driver

Downstream consumer of the Nios system's 8-bit LED PIO export (`po_led_external_connection_export`). It turns the firmware-written PIO word into a registered drive for the board's 8 LEDs. The block supports four display modes: static, blink, PWM dim and chase. Firmware therefore signals wallet status (idle, busy, error, confirm) with one PIO write and no CPU polling loop.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clock cycles per tick (1 ms at 50 MHz).
- `BLINK_TICKS`, default 250: ticks per blink half-period.
- `CHASE_TICKS`, default 100: ticks per chase step.
- `PWM_BITS`, default 4: PWM counter width; duty is taken from `pio_word[PWM_BITS-1:0]`.

Ports:
- `clk_clk`  in  1: system clock, same domain as the Nios/PIO.
- `reset_reset`  in  1: reset, synchronous, active-high.
- `pio_word`  in  8: connected to `po_led_external_connection_export`. `[7:6]` is the mode and `[5:0]` is the parameter.
- `led`  out  8: registered LED drive, 1 = lit.

## Operation
- Modes, decoded from `pio_word[7:6]`:
  - `00` STATIC: `led = {2'b00, pio_word[5:0]}`.
  - `01` BLINK: `led = phase ? {2'b00, pio_word[5:0]} : 8'h00`.
    - `phase` starts at 1 and toggles every `BLINK_TICKS` ticks.
  - `10` PWM: `led = (pwm_cnt < duty) ? 8'hFF : 8'h00`.
    - `pwm_cnt` increments every clock, modulo 2^`PWM_BITS`.
    - `duty` is latched only when `pwm_cnt == 0`, so there are no partial periods.
    - Duty 0 keeps the LEDs always off. Maximum duty gives (2^N − 1)/2^N on.
  - `11` CHASE: `led` is one-hot and advances one position every `CHASE_TICKS` ticks.
    - `pio_word[0] = 0`: starts at bit 0 and moves upward; 7 wraps to 0.
    - `pio_word[0] = 1`: starts at bit 7 and moves downward; 0 wraps to 7.
- Change detection:
  - `word_q` holds the last sampled `pio_word`.
  - When `pio_word != word_q`, the restart condition applies in that same cycle:
    - tick prescaler, blink/chase tick counters and `pwm_cnt` clear to 0;
    - `phase` is set to 1;
    - chase position is set to its start bit;
    - `duty` loads the new value;
    - `word_q` loads `pio_word`.
- Any change restarts timing, including a change to the parameter field only.
- Simultaneous events: a word change in the same cycle as a tick or step means the change wins. The tick is discarded.
- Tick generator:
  - Counter runs from 0 to `TICK_DIV−1`.
  - A one-cycle `tick` pulse fires when the count equals `TICK_DIV−1`; the counter then wraps to 0.
  - The blink counter and chase counter each count ticks with the same wrap rule.
- Counter widths: `$clog2` of the terminal value; no counter may overflow.
- Reset outputs and internal state:
  - `led = 8'h00`.
  - `word_q = 8'h00`, so the block comes up in STATIC with pattern 0.
  - All counters 0, `phase = 1`, chase position = bit 0.
  - A reset in the middle of any mode forces this state on the next edge.

## Timing
- Latency from `pio_word` change to `led` is exactly 1 clock.
  - The first `led` value after a change is the mode's start value: pattern, phase-on pattern, duty at `cnt = 0`, or the chase start bit.
- BLINK: the first toggle is `TICK_DIV*BLINK_TICKS` cycles after the update edge. Half-periods are equal.
- CHASE: each position is held for `TICK_DIV*CHASE_TICKS` cycles.
- PWM: the period is 2^`PWM_BITS` cycles. LEDs are high for cycles 0..duty−1 of each period.
- There is no handshake. The PIO holds its value until firmware rewrites it.

## Structure
- Package `led_status_pkg` contains:
  - `led_mode_t` enum: `MODE_STATIC`, `MODE_BLINK`, `MODE_PWM`, `MODE_CHASE` (2 bits);
  - `LED_W = 8` and `PARAM_W = 6` constants.
- Sub-module `led_tick_gen` (parameter `TICK_DIV`; ports `clk_clk`, `reset_reset`, `clr`, `tick`) holds the prescaler.
- The top level holds the change detector, mode mux, blink/chase/PWM logic and the output register.

## Test plan
All scenarios use `TICK_DIV=4`, `BLINK_TICKS=2`, `CHASE_TICKS=1`, `PWM_BITS=4`.
- Reset, then `pio_word = 8'h15` → `led = 8'h00` during reset; `led = 8'h15` 1 clock after the change, held steady.
- `pio_word = 8'h6A` (BLINK, pattern `0x2A`) → `led` repeats `0x2A` ×8 cycles then `0x00` ×8 cycles; check 3 full periods.
- `pio_word = 8'h84` (PWM, duty 4) → each 16-cycle window shows `8'hFF` ×4 then `8'h00` ×12. A rewrite to `8'h80` gives a constant `00`.
- `pio_word = 8'hC0`, then `8'hC1` → up-chase `01, 02, 04 … 80, 01`, each held 4 cycles. After the change: `80, 40, …` starting 1 clock after the write.
- Rewrite `8'h6A` → `8'h6B` on the exact cycle a blink toggle is due → `led = 8'h2B` next cycle, with the next toggle a full 8 cycles later.
- Assert `reset_reset` mid-CHASE → `led = 8'h00` next edge. After release, the block shows STATIC with `word_q = 0` until `pio_word` differs.
